// File: rtl/el2_pkg.sv
// Shared branch-predictor package.
// Holds the global-history width and the GHR value type used by the
// predictor front end (el2_btb_ghr_hash, el2_bp_ghr_ctl).
package el2_pkg;

  // Mirrors pt.BHT_GHR_SIZE of the core configuration.
  localparam int EL2_GHR_W = 8;

  typedef logic [EL2_GHR_W-1:0] el2_ghr_t;

endpackage : el2_pkg

// File: rtl/el2_ghr_ckpt_fifo.sv
// Checkpoint FIFO for speculative global history.
// One entry is pushed per accepted branch prediction and popped when the
// oldest branch resolves. A truncate request empties the buffer by moving
// the tail to the (post-pop) head, discarding every younger checkpoint.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset (pointers/count only)
//   push        write push_data at tail, advance tail
//   push_data   GHR snapshot to checkpoint
//   pop         advance head (oldest branch resolved)
//   trunc       discard all entries: tail <= next head, count <= 0
//   head, tail  read/write pointers
//   count       occupied entries (0..CKPT_DEPTH)
//   head_data   checkpoint at the head pointer
module el2_ghr_ckpt_fifo
  import el2_pkg::*;
#(
  parameter int GHR_SIZE   = EL2_GHR_W,
  parameter int CKPT_DEPTH = 8,
  parameter int PTR_W      = $clog2(CKPT_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [GHR_SIZE-1:0] push_data,
  input  logic                pop,
  input  logic                trunc,
  output logic [PTR_W-1:0]    head,
  output logic [PTR_W-1:0]    tail,
  output logic [PTR_W:0]      count,
  output logic [GHR_SIZE-1:0] head_data
);

  logic [GHR_SIZE-1:0] mem [CKPT_DEPTH];
  logic [PTR_W-1:0]    head_nxt;
  logic [PTR_W-1:0]    tail_nxt;
  logic [PTR_W:0]      count_nxt;

  // Power-of-two depth: pointer arithmetic wraps naturally.
  always_comb begin
    head_nxt  = pop  ? head + PTR_W'(1) : head;
    tail_nxt  = push ? tail + PTR_W'(1) : tail;
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: count_nxt = count;
    endcase
    if (trunc) begin
      tail_nxt  = head_nxt;
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
    end
  end

  // Storage carries data only; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  assign head_data = mem[head];

endmodule : el2_ghr_ckpt_fifo

// File: rtl/el2_bp_ghr_ctl.sv
// Global history register control for the branch predictor.
// Maintains the speculative fetch GHR (ghr_f, feeds el2_btb_ghr_hash) and
// the committed GHR (ghr_commit). Each accepted prediction checkpoints the
// pre-prediction ghr_f; a mispredict rebuilds ghr_f from the head
// checkpoint plus the actual direction, and a non-branch flush copies the
// committed history back into ghr_f.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   pred_valid_f    conditional branch predicted in F
//   pred_taken_f    predicted direction
//   pred_ready_f    checkpoint accepted this cycle (combinational)
//   pred_tag_f      tag for the allocated checkpoint (= tail pointer)
//   ghr_f           speculative GHR
//   res_valid       oldest in-flight branch resolves
//   res_tag         tag of resolving branch
//   res_taken       actual direction
//   res_mispredict  actual direction differs from prediction
//   flush_other     non-branch flush
//   ghr_commit      architectural GHR
//   ckpt_count      occupied checkpoint entries
//   tag_err         one-cycle pulse after a resolve with a bad tag / empty buffer
module el2_bp_ghr_ctl
  import el2_pkg::*;
#(
  parameter int GHR_SIZE   = EL2_GHR_W,
  parameter int CKPT_DEPTH = 8,
  parameter int PTR_W      = $clog2(CKPT_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid_f,
  input  logic                pred_taken_f,
  output logic                pred_ready_f,
  output logic [PTR_W-1:0]    pred_tag_f,
  output logic [GHR_SIZE-1:0] ghr_f,
  input  logic                res_valid,
  input  logic [PTR_W-1:0]    res_tag,
  input  logic                res_taken,
  input  logic                res_mispredict,
  input  logic                flush_other,
  output logic [GHR_SIZE-1:0] ghr_commit,
  output logic [PTR_W:0]      ckpt_count,
  output logic                tag_err
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(CKPT_DEPTH);

  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [GHR_SIZE-1:0] head_data;
  logic                alloc;
  logic                res_good;
  logic                res_bad;
  logic                mispred;
  logic [GHR_SIZE-1:0] ghr_f_nxt;
  logic [GHR_SIZE-1:0] ghr_commit_nxt;

  // Ready ignores an entry freed this cycle, keeping the full check off
  // the resolve path.
  assign pred_ready_f = (ckpt_count < DEPTH_C) & ~(res_valid & res_mispredict) & ~flush_other;
  assign alloc        = pred_valid_f & pred_ready_f;
  assign res_good     = res_valid & (ckpt_count != '0) & (res_tag == head);
  assign res_bad      = res_valid & ~res_good;
  assign mispred      = res_good & res_mispredict;
  assign pred_tag_f   = tail;

  // Priority: flush_other > mispredict > allocate. The flush uses the
  // committed history including any same-cycle good resolve.
  always_comb begin
    ghr_commit_nxt = ghr_commit;
    if (res_good) ghr_commit_nxt = {ghr_commit[GHR_SIZE-2:0], res_taken};
    ghr_f_nxt = ghr_f;
    if (flush_other)  ghr_f_nxt = ghr_commit_nxt;
    else if (mispred) ghr_f_nxt = {head_data[GHR_SIZE-2:0], res_taken};
    else if (alloc)   ghr_f_nxt = {ghr_f[GHR_SIZE-2:0], pred_taken_f};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_f      <= '0;
      ghr_commit <= '0;
      tag_err    <= 1'b0;
    end else begin
      ghr_f      <= ghr_f_nxt;
      ghr_commit <= ghr_commit_nxt;
      tag_err    <= res_bad;
    end
  end

  el2_ghr_ckpt_fifo #(
    .GHR_SIZE  (GHR_SIZE),
    .CKPT_DEPTH(CKPT_DEPTH),
    .PTR_W     (PTR_W)
  ) u_ckpt (
    .clk      (clk),
    .rst      (rst),
    .push     (alloc),
    .push_data(ghr_f),
    .pop      (res_good),
    .trunc    (mispred | flush_other),
    .head     (head),
    .tail     (tail),
    .count    (ckpt_count),
    .head_data(head_data)
  );

  // The oldest checkpoint always equals the committed history.
  a_head_matches_commit: assert property (
    @(posedge clk) disable iff (rst) (ckpt_count != '0) |-> (head_data == ghr_commit)
  );

endmodule : el2_bp_ghr_ctl

// File: tb/tb_el2_bp_ghr_ctl.sv
module tb_el2_bp_ghr_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pred_valid_f, pred_taken_f, pred_ready_f;
  logic [2:0] pred_tag_f;
  logic [7:0] ghr_f;
  logic       res_valid;
  logic [2:0] res_tag;
  logic       res_taken, res_mispredict, flush_other;
  logic [7:0] ghr_commit;
  logic [3:0] ckpt_count;
  logic       tag_err;

  int n_chk  = 0;
  int n_pass = 0;

  el2_bp_ghr_ctl #(.GHR_SIZE(8), .CKPT_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .pred_valid_f(pred_valid_f), .pred_taken_f(pred_taken_f),
    .pred_ready_f(pred_ready_f), .pred_tag_f(pred_tag_f), .ghr_f(ghr_f),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .flush_other(flush_other),
    .ghr_commit(ghr_commit), .ckpt_count(ckpt_count), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid_f = 0; pred_taken_f = 0; res_valid = 0; res_tag = 0;
    res_taken = 0; res_mispredict = 0; flush_other = 0;
  endtask

  task automatic alloc(input logic t);
    pred_valid_f = 1; pred_taken_f = t;
    step();
    pred_valid_f = 0;
  endtask

  task automatic resolve(input logic [2:0] tg, input logic t, input logic mp);
    res_valid = 1; res_tag = tg; res_taken = t; res_mispredict = mp;
    step();
    res_valid = 0; res_mispredict = 0;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] f, input logic [7:0] c,
                           input logic [3:0] n, input logic [2:0] tl);
    chk({tag, ".ghr_f"}, 32'(ghr_f), 32'(f));
    chk({tag, ".ghr_commit"}, 32'(ghr_commit), 32'(c));
    chk({tag, ".count"}, 32'(ckpt_count), 32'(n));
    chk({tag, ".tag"}, 32'(pred_tag_f), 32'(tl));
  endtask

  logic [7:0] ef, ec;
  logic       t;

  initial begin
    idle();
    rst = 1;
    repeat (2) step();
    chk_state("rst_hold", 8'h00, 8'h00, 0, 0);
    chk("rst_hold.tag_err", 32'(tag_err), 0);
    rst = 0;
    step();
    chk("rst.ready", 32'(pred_ready_f), 1);
    chk_state("rst", 8'h00, 8'h00, 0, 0);

    // Scenario 1: T, NT, T
    alloc(1); chk_state("s1.a0", 8'h01, 8'h00, 1, 1);
    alloc(0); chk_state("s1.a1", 8'h02, 8'h00, 2, 2);
    alloc(1); chk_state("s1.a2", 8'h05, 8'h00, 3, 3);

    // Scenario 3: tag0 predicted taken, actually not taken
    res_valid = 1; res_tag = 0; res_mispredict = 1; pred_valid_f = 1; pred_taken_f = 1;
    #1 chk("s3.ready", 32'(pred_ready_f), 0);
    pred_valid_f = 0;
    resolve(0, 0, 1);
    chk_state("s3", 8'h00, 8'h00, 0, 1);

    // Scenario 5: resolve while empty, then with wrong tag
    resolve(1, 1, 0);
    chk("s5.empty.tag_err", 32'(tag_err), 1);
    chk_state("s5.empty", 8'h00, 8'h00, 0, 1);
    step();
    chk("s5.pulse_end", 32'(tag_err), 0);
    alloc(1); chk_state("s5.alloc", 8'h01, 8'h00, 1, 2);
    resolve(0, 1, 0);
    chk("s5.badtag.tag_err", 32'(tag_err), 1);
    chk_state("s5.badtag", 8'h01, 8'h00, 1, 2);

    // Scenario 4: second alloc, then flush with good resolve of head (tag1)
    alloc(0); chk_state("s4.alloc", 8'h02, 8'h00, 2, 3);
    flush_other = 1;
    resolve(1, 1, 0);
    flush_other = 0;
    chk_state("s4.flush", 8'h01, 8'h01, 0, 2);
    chk("s4.tag_err", 32'(tag_err), 0);

    // Scenario 2: fill all 8 entries with taken predictions (tags 2..1)
    for (int i = 0; i < 8; i++) alloc(1);
    chk_state("s2.full", 8'hFF, 8'h01, 8, 2);
    pred_valid_f = 1; pred_taken_f = 0;
    #1 chk("s2.full.ready", 32'(pred_ready_f), 0);
    step();
    chk_state("s2.dropped", 8'hFF, 8'h01, 8, 2);
    res_valid = 1; res_tag = 2; res_taken = 1; res_mispredict = 0;
    #1 chk("s2.samecyc.ready", 32'(pred_ready_f), 0);
    step();
    res_valid = 0;
    chk_state("s2.freed", 8'hFF, 8'h03, 7, 2);
    chk("s2.retry.ready", 32'(pred_ready_f), 1);
    step();
    pred_valid_f = 0;
    chk_state("s2.accepted", 8'hFE, 8'h03, 8, 3);

    // Async reset mid-cycle
    #3 rst = 1;
    #1 chk_state("async_rst", 8'h00, 8'h00, 0, 0);
    step();
    rst = 0;
    step();

    // Scenario 6: 24 allocate/resolve pairs, pointers wrap three times
    ef = 8'h00; ec = 8'h00;
    for (int i = 0; i < 24; i++) begin
      t = ((i % 3) == 1);
      alloc(t);
      ef = {ef[6:0], t};
      chk("s6.alloc.ghr_f", 32'(ghr_f), 32'(ef));
      resolve(3'(i), t, 0);
      ec = {ec[6:0], t};
      chk("s6.res.ghr_commit", 32'(ghr_commit), 32'(ec));
      chk("s6.res.count", 32'(ckpt_count), 0);
      chk("s6.res.tag_err", 32'(tag_err), 0);
    end
    chk("s6.wrap.tag", 32'(pred_tag_f), 0);

    // Reset in the middle of outstanding predictions
    alloc(1); alloc(1);
    chk("s6.mid.count", 32'(ckpt_count), 2);
    #2 rst = 1;
    #1 chk_state("s6.mid_rst", 8'h00, 8'h00, 0, 0);
    step();
    rst = 0;
    step();
    chk("s6.after_rst.ready", 32'(pred_ready_f), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_el2_bp_ghr_ctl
